tot_pulse_gen: RTL and testbench
================================

# tot_pulse_gen

Programmable time-over-threshold test-pulse synthesizer for the sigdel frontend. It drives the same two-phase comparator interface that the energy-counting path consumes. `signal_rising` is the sample on the rising half-cycle and `signal_falling` is the sample on the falling half-cycle. A main pulse of programmed half-cycle width is followed by optional trailing glitch pulses and then an idle holdoff. It is used for in-system calibration and for closed-loop verification of energy measurement and trailing-pulse filtering.

## Interface
- `HOLDOFF`, default 20: low cycles enforced after the last high slot before the next trigger is accepted. Must be > 16.
- `clk` in, 1 bit: system clock.
- `rst` in, 1 bit: asynchronous, active-high reset.
- `trig` in, 1 bit: start request. Sampled only when `busy`=0.
- `width` in, 12 bits: main pulse length in half-cycles.
- `phase` in, 1 bit: 0 = main pulse starts on the rising half; 1 = it starts on the falling half.
- `n_tail` in, 3 bits: number of trailing pulses, 0..7.
- `tail_width` in, 8 bits: length of each trailing pulse in half-cycles.
- `tail_gap` in, 8 bits: low full cycles between pulses. A value of 0 is treated as 1.
- `signal_rising` out, 1 bit: rising-half sample. Registered.
- `signal_falling` out, 1 bit: falling-half sample. Registered.
- `busy` out, 1 bit: high from the cycle after acceptance through the end of holdoff.
- `done` out, 1 bit: one-cycle strobe on the final holdoff cycle.

## Operation
- **States:** IDLE, MAIN, GAP, TAIL, HOLD.
- **Latching:** all inputs are latched when `trig`=1 and `busy`=0 in IDLE. Input changes afterwards have no effect on the sequence in progress.
- **Half-slot numbering:**
  - Slot 2k is the rising half of cycle A+1+k; slot 2k+1 is the falling half of that cycle.
  - A is the acceptance cycle.
- **MAIN:**
  - Occupies slots `phase` through `phase+width-1`.
  - Output of a cycle is {rising, falling} = the high/low state of its two slots.
  - If `width`=0, MAIN is skipped.
- **Next state after MAIN:**
  - GAP if `n_tail`>0.
  - Otherwise HOLD.
  - Leave MAIN after the cycle that contains the last high slot (cycle M).
- **GAP:**
  - Both outputs 0 for max(`tail_gap`,1) cycles.
  - Then go to TAIL.
- **TAIL:**
  - Each trailing pulse always starts on a rising half.
  - It occupies `tail_width` consecutive slots.
  - If `tail_width`=0, the pulse is empty: the cycle count still advances, but nothing is driven high.
  - After each pulse, decrement the remaining count. Go to GAP if the count is nonzero, otherwise HOLD.
- **HOLD:**
  - Both outputs 0 for `HOLDOFF` cycles.
  - `done`=1 on the last of these cycles.
  - Then go to IDLE, with `busy`=0 on the next cycle.
- **Empty sequence:** if `width`=0 and `n_tail`=0, the block goes directly to HOLD.
- **Half-slot accounting:** the total number of high half-slots equals `width` + `n_tail`×`tail_width`, up to 5880. Consumers with 12-bit accumulators wrap modulo 4096; the generator does not saturate.
- **Trigger while busy:** `trig` while `busy`=1 is ignored. Triggers are not queued.
- **Counters:** internal counters are sized to full operand ranges (13-bit half-slot counter, 8-bit gap counter, 3-bit tail counter, HOLDOFF-sized holdoff counter). No wrap is possible within a sequence.

## Timing
- **Reset:**
  - `rst` asserted forces, asynchronously: state IDLE, and `signal_rising`, `signal_falling`, `busy`, `done` all 0.
  - Latched parameters and counters are cleared.
  - Reset mid-sequence aborts immediately; no `done` is issued.
- **After reset:** the first `trig` is honoured on the first rising `clk` after `rst` deasserts.
- **Acceptance to outputs:** with acceptance at cycle A, `busy`=1 at A+1 and the first possible high output is at A+1.
- **Main pulse end:** the last high main cycle is M = A + ceil((`phase`+`width`)/2).
- **Tail timing:** tail pulse j (0-based) starts at the cycle after its preceding gap ends.
- **Busy/done end:** with L = the last high cycle, `done`=1 at L+`HOLDOFF` and `busy`=0 at L+`HOLDOFF`+1. With no high cycles, L = A.
- **Back-to-back triggers:** a `trig` held continuously restarts at L+`HOLDOFF`+1, which is the first IDLE cycle.

## Test plan
- **Even width:** after reset, `trig` with `width`=6, `phase`=0, `n_tail`=0 → `{rising,falling}`=11 for 3 cycles starting at A+1, then 00; `done` at A+3+20; `busy` low at A+24.
- **Odd width, falling start:** `width`=5, `phase`=1 → per-cycle outputs 01, 11, 11; total high slots = 5.
- **Trailing pulses:** `width`=8, `n_tail`=2, `tail_width`=3, `tail_gap`=4 → 11×4; 00×4; 11, 10; 00×4; 11, 10; then HOLD. High-slot total = 14.
- **Zero-value edges:**
  - `width`=0, `n_tail`=0 → outputs never go high; `done` at A+20.
  - `tail_gap`=0 behaves identically to `tail_gap`=1.
- **Trigger during busy, then reset:**
  - A second `trig` pulse while `busy`=1 produces no second sequence.
  - Asserting `rst` mid-MAIN with `width`=100 → outputs and `busy` go to 0 without waiting for a clock edge; no `done` is issued.
- **Closed loop:** drive the energy-counting path with `width`=1000, `n_tail`=3, `tail_width`=10, `tail_gap`=2 → one event is reported with energy 1030; a single active window is observed.

Source files
------------

// File: rtl/tot_pulse_gen.sv
// Time-over-threshold test-pulse synthesizer: emits a main pulse and optional trailing
// pulses on a two-phase (rising/falling half-cycle) comparator-style interface.
module tot_pulse_gen #(
  parameter int HOLDOFF = 20
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        trig_i,
  input  logic [11:0] width_i,
  input  logic        phase_i,
  input  logic [2:0]  n_tail_i,
  input  logic [7:0]  tail_width_i,
  input  logic [7:0]  tail_gap_i,
  output logic        signal_rising_o,
  output logic        signal_falling_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int HW = $clog2(HOLDOFF);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF - 1);

  typedef enum logic [2:0] {S_IDLE, S_MAIN, S_GAP, S_TAIL, S_HOLD} state_t;

  state_t        state_q, state_d;
  logic [12:0]   slot_q, slot_d;
  logic [7:0]    gap_q, gap_d;
  logic [7:0]    gap_len_q, gap_len_d;
  logic [2:0]    tail_q, tail_d;
  logic [7:0]    tail_width_q, tail_width_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [7:0]    gap_len_new;
  logic [14:0]   em;

  // One cycle of half-slot emission: returns {rising, falling, remaining_slots}.
  function automatic logic [14:0] emit(input logic [12:0] rem, input logic fall_only);
    logic        r;
    logic        f;
    logic [12:0] n;
    if (fall_only) begin
      r = 1'b0;
      f = (rem != 13'd0);
      n = (rem != 13'd0) ? rem - 13'd1 : rem;
    end else begin
      r = (rem != 13'd0);
      f = (rem > 13'd1);
      n = (rem > 13'd1) ? rem - 13'd2 : 13'd0;
    end
    return {r, f, n};
  endfunction

  assign gap_len_new = (tail_gap_i == 8'd0) ? 8'd1 : tail_gap_i;

  // The combinational block decides the state and outputs of the upcoming cycle, so
  // the registered outputs line up with the state register (first high cycle is A+1).
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    gap_d        = gap_q;
    gap_len_d    = gap_len_q;
    tail_d       = tail_q;
    tail_width_d = tail_width_q;
    hold_d       = hold_q;
    rise_d       = 1'b0;
    fall_d       = 1'b0;
    done_d       = 1'b0;
    em           = '0;
    case (state_q)
      S_IDLE: begin
        if (trig_i) begin
          gap_len_d    = gap_len_new;
          tail_d       = n_tail_i;
          tail_width_d = tail_width_i;
          if (width_i != 12'd0) begin
            em                       = emit({1'b0, width_i}, phase_i);
            {rise_d, fall_d, slot_d} = em;
            state_d                  = S_MAIN;
          end else if (n_tail_i != 3'd0) begin
            gap_d   = gap_len_new - 8'd1;
            state_d = S_GAP;
          end else begin
            hold_d  = HOLD_LOAD;
            state_d = S_HOLD;
          end
        end
      end
      S_MAIN, S_TAIL: begin
        if (slot_q != 13'd0) begin
          em                       = emit(slot_q, 1'b0);
          {rise_d, fall_d, slot_d} = em;
        end else if (tail_q != 3'd0) begin
          gap_d   = gap_len_q - 8'd1;
          state_d = S_GAP;
        end else begin
          hold_d  = HOLD_LOAD;
          state_d = S_HOLD;
        end
      end
      S_GAP: begin
        if (gap_q != 8'd0) begin
          gap_d = gap_q - 8'd1;
        end else begin
          // A zero-width tail still spends one (low) cycle in TAIL.
          tail_d                   = tail_q - 3'd1;
          em                       = emit({5'd0, tail_width_q}, 1'b0);
          {rise_d, fall_d, slot_d} = em;
          state_d                  = S_TAIL;
        end
      end
      S_HOLD: begin
        if (hold_q != '0) begin
          hold_d = hold_q - HW'(1);
          done_d = (hold_q == HW'(1));
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      slot_q       <= '0;
      gap_q        <= '0;
      gap_len_q    <= '0;
      tail_q       <= '0;
      tail_width_q <= '0;
      hold_q       <= '0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      gap_q        <= gap_d;
      gap_len_q    <= gap_len_d;
      tail_q       <= tail_d;
      tail_width_q <= tail_width_d;
      hold_q       <= hold_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign signal_rising_o  = rise_q;
  assign signal_falling_o = fall_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;

endmodule

// File: tb/tb_tot_pulse_gen.sv
// Directed bench for tot_pulse_gen: per-cycle output tables, holdoff/done timing,
// zero edges, busy-trigger rejection, async reset abort and a slot-count loop.
module tb_tot_pulse_gen;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        trig_i;
  logic [11:0] width_i;
  logic        phase_i;
  logic [2:0]  n_tail_i;
  logic [7:0]  tail_width_i;
  logic [7:0]  tail_gap_i;
  logic        signal_rising_o;
  logic        signal_falling_o;
  logic        busy_o;
  logic        done_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [1:0] out_h  [0:63];
  logic       busy_h [0:63];
  logic       done_h [0:63];

  tot_pulse_gen #(.HOLDOFF(20)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .trig_i          (trig_i),
    .width_i         (width_i),
    .phase_i         (phase_i),
    .n_tail_i        (n_tail_i),
    .tail_width_i    (tail_width_i),
    .tail_gap_i      (tail_gap_i),
    .signal_rising_o (signal_rising_o),
    .signal_falling_o(signal_falling_o),
    .busy_o          (busy_o),
    .done_o          (done_o)
  );

  always #5 clk_i = ~clk_i;

  // Leaves the bench sampling cycle A+1; inputs are then scrambled to prove latching.
  task automatic start_seq(input logic [11:0] w, input logic ph, input logic [2:0] nt,
                           input logic [7:0] tw, input logic [7:0] tg);
    width_i = w; phase_i = ph; n_tail_i = nt; tail_width_i = tw; tail_gap_i = tg;
    trig_i = 1'b1;
    @(posedge clk_i); #1;
    trig_i = 1'b0;
    width_i = 12'd7; phase_i = 1'b1; n_tail_i = 3'd7; tail_width_i = 8'd255; tail_gap_i = 8'd255;
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      out_h[i]  = {signal_rising_o, signal_falling_o};
      busy_h[i] = busy_o;
      done_h[i] = done_o;
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b1; trig_i = 1'b0;
    width_i = '0; phase_i = 1'b0; n_tail_i = '0; tail_width_i = '0; tail_gap_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    total_cnt++;
    if ({signal_rising_o, signal_falling_o} !== 2'b00) $display("FAIL reset_out got=%b want=00", {signal_rising_o, signal_falling_o});
    else pass_cnt++;
    total_cnt++;
    if (busy_o !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy_o);
    else pass_cnt++;
    total_cnt++;
    if (done_o !== 1'b0) $display("FAIL reset_done got=%b want=0", done_o);
    else pass_cnt++;
    rst_i = 1'b0;
  endtask

  task automatic test_even_width;
    logic [1:0] eo;
    start_seq(12'd6, 1'b0, 3'd0, 8'd0, 8'd0);
    capture(26);
    for (int i = 0; i < 26; i++) begin
      eo = (i < 3) ? 2'b11 : 2'b00;
      total_cnt++;
      if (out_h[i] !== eo || done_h[i] !== (i == 22) || busy_h[i] !== (i < 23))
        $display("FAIL even_width idx=%0d got out=%b busy=%b done=%b want out=%b busy=%b done=%b",
                 i, out_h[i], busy_h[i], done_h[i], eo, (i < 23), (i == 22));
      else pass_cnt++;
    end
  endtask

  task automatic test_odd_falling;
    logic [1:0] eo;
    int slots;
    slots = 0;
    start_seq(12'd5, 1'b1, 3'd0, 8'd0, 8'd0);
    capture(25);
    for (int i = 0; i < 25; i++) begin
      eo = (i == 0) ? 2'b01 : (i < 3) ? 2'b11 : 2'b00;
      slots += int'(out_h[i][1]) + int'(out_h[i][0]);
      total_cnt++;
      if (out_h[i] !== eo || done_h[i] !== (i == 22))
        $display("FAIL odd_falling idx=%0d got out=%b done=%b want out=%b done=%b", i, out_h[i], done_h[i], eo, (i == 22));
      else pass_cnt++;
    end
    total_cnt++;
    if (slots !== 5) $display("FAIL odd_slots got=%0d want=5", slots);
    else pass_cnt++;
  endtask

  task automatic test_tails;
    logic [1:0] eo;
    int slots;
    slots = 0;
    start_seq(12'd8, 1'b0, 3'd2, 8'd3, 8'd4);
    capture(40);
    for (int i = 0; i < 40; i++) begin
      if (i < 4 || i == 8 || i == 14) eo = 2'b11;
      else if (i == 9 || i == 15) eo = 2'b10;
      else eo = 2'b00;
      slots += int'(out_h[i][1]) + int'(out_h[i][0]);
      total_cnt++;
      if (out_h[i] !== eo || done_h[i] !== (i == 35) || busy_h[i] !== (i < 36))
        $display("FAIL tails idx=%0d got out=%b busy=%b done=%b want out=%b busy=%b done=%b",
                 i, out_h[i], busy_h[i], done_h[i], eo, (i < 36), (i == 35));
      else pass_cnt++;
    end
    total_cnt++;
    if (slots !== 14) $display("FAIL tail_slots got=%0d want=14", slots);
    else pass_cnt++;
  endtask

  task automatic test_zero_empty;
    start_seq(12'd0, 1'b0, 3'd0, 8'd5, 8'd5);
    capture(22);
    for (int i = 0; i < 22; i++) begin
      total_cnt++;
      if (out_h[i] !== 2'b00 || done_h[i] !== (i == 19) || busy_h[i] !== (i < 20))
        $display("FAIL zero_empty idx=%0d got out=%b busy=%b done=%b want out=00 busy=%b done=%b",
                 i, out_h[i], busy_h[i], done_h[i], (i < 20), (i == 19));
      else pass_cnt++;
    end
  endtask

  task automatic test_gap_zero;
    logic [1:0] eo;
    logic [7:0] tgv;
    for (int k = 0; k < 2; k++) begin
      tgv = 8'(k);
      start_seq(12'd2, 1'b0, 3'd1, 8'd2, tgv);
      capture(26);
      for (int i = 0; i < 26; i++) begin
        eo = (i == 0 || i == 2) ? 2'b11 : 2'b00;
        total_cnt++;
        if (out_h[i] !== eo || done_h[i] !== (i == 22))
          $display("FAIL gap_zero tg=%0d idx=%0d got out=%b done=%b want out=%b done=%b",
                   k, i, out_h[i], done_h[i], eo, (i == 22));
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_trig_busy;
    int highs;
    int dones;
    int busy_late;
    highs = 0; dones = 0; busy_late = 0;
    start_seq(12'd4, 1'b0, 3'd0, 8'd0, 8'd0);
    for (int i = 0; i < 40; i++) begin
      if (out_h[0] === 2'bxx) highs = highs;
      if ({signal_rising_o, signal_falling_o} != 2'b00) highs++;
      if (done_o) dones++;
      if (i >= 22 && busy_o) busy_late++;
      trig_i = (i == 5);
      if (i == 5) begin
        width_i = 12'd6; phase_i = 1'b0; n_tail_i = 3'd0;
      end
      @(posedge clk_i); #1;
    end
    trig_i = 1'b0;
    total_cnt++;
    if (highs !== 2) $display("FAIL trig_busy_highs got=%0d want=2", highs);
    else pass_cnt++;
    total_cnt++;
    if (dones !== 1) $display("FAIL trig_busy_dones got=%0d want=1", dones);
    else pass_cnt++;
    total_cnt++;
    if (busy_late !== 0) $display("FAIL trig_busy_restart got=%0d want=0", busy_late);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int dones;
    int highs;
    dones = 0; highs = 0;
    start_seq(12'd100, 1'b0, 3'd0, 8'd0, 8'd0);
    capture(5);
    #2 rst_i = 1'b1;
    #1;
    total_cnt++;
    if ({signal_rising_o, signal_falling_o, busy_o} !== 3'b000)
      $display("FAIL reset_mid_async got=%b want=000", {signal_rising_o, signal_falling_o, busy_o});
    else pass_cnt++;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done_o) dones++;
      if (busy_o || signal_rising_o || signal_falling_o) highs++;
      @(posedge clk_i); #1;
    end
    total_cnt++;
    if (dones !== 0) $display("FAIL reset_mid_done got=%0d want=0", dones);
    else pass_cnt++;
    total_cnt++;
    if (highs !== 0) $display("FAIL reset_mid_quiet got=%0d want=0", highs);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    start_seq(12'd2, 1'b0, 3'd0, 8'd0, 8'd0);
    width_i = 12'd2; phase_i = 1'b0; n_tail_i = 3'd0; tail_width_i = 8'd0; tail_gap_i = 8'd0;
    trig_i = 1'b1;
    capture(24);
    trig_i = 1'b0;
    total_cnt++;
    if (done_h[20] !== 1'b1 || done_h[19] !== 1'b0) $display("FAIL b2b_done got=%b%b want=01", done_h[19], done_h[20]);
    else pass_cnt++;
    total_cnt++;
    if (busy_h[21] !== 1'b0 || busy_h[22] !== 1'b1) $display("FAIL b2b_busy got=%b%b want=01", busy_h[21], busy_h[22]);
    else pass_cnt++;
    total_cnt++;
    if (out_h[22] !== 2'b11 || out_h[21] !== 2'b00) $display("FAIL b2b_restart got=%b,%b want=00,11", out_h[21], out_h[22]);
    else pass_cnt++;
    capture(30);
  endtask

  task automatic test_closed_loop;
    int energy;
    int windows;
    int dones;
    int cyc;
    logic prev_busy;
    energy = 0; windows = 0; dones = 0; cyc = 0; prev_busy = 1'b0;
    start_seq(12'd1000, 1'b0, 3'd3, 8'd10, 8'd2);
    while (busy_o && cyc < 1000) begin
      energy += int'(signal_rising_o) + int'(signal_falling_o);
      if (busy_o && !prev_busy) windows++;
      if (done_o) dones++;
      prev_busy = busy_o;
      cyc++;
      @(posedge clk_i); #1;
    end
    total_cnt++;
    if (cyc >= 1000) $display("FAIL closed_loop_timeout got=%0d want<1000", cyc);
    else pass_cnt++;
    total_cnt++;
    if (energy !== 1030) $display("FAIL closed_loop_energy got=%0d want=1030", energy);
    else pass_cnt++;
    total_cnt++;
    if (windows !== 1 || dones !== 1) $display("FAIL closed_loop_events got=%0d/%0d want=1/1", windows, dones);
    else pass_cnt++;
    total_cnt++;
    if (cyc !== 541) $display("FAIL closed_loop_len got=%0d want=541", cyc);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_even_width();
    test_odd_falling();
    test_tails();
    test_zero_empty();
    test_gap_zero();
    test_trig_busy();
    test_reset_mid();
    test_back_to_back();
    test_closed_loop();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
